obi_sba_arbiter: RTL and testbench

- Two-master to one-slave OBI-style arbiter.
- Merges the core data port (master 0) and the debug module system-bus master (master 1) onto the single data/SBA port of the memory-mapped RAM.
- Sits between the core/dm_top bus masters and mm_ram.
- Round-robin, in-order response routing through an owner-ID FIFO, bounded outstanding transactions.

---
 rtl/obi_arb_pkg.sv | 24 ++
 rtl/obi_owner_fifo.sv | 59 +++++
 rtl/obi_sba_arbiter.sv | 130 +++++++++++++
 tb/tb_obi_sba_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types for the two-master OBI arbiter in front of mm_ram.
package obi_arb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_SBA  = 1'b1
    } owner_id_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    we;
        logic [DATA_WIDTH/8-1:0] be;
        logic [DATA_WIDTH-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [DATA_WIDTH-1:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/obi_owner_fifo.sv
// Owner-ID FIFO: remembers which master each granted transaction belongs to,
// so in-order responses can be steered back. Full blocks push even on pop.
module obi_owner_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push,
    input  owner_id_e push_id,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output owner_id_e head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    owner_id_e          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];

    // Pointer, count and storage update; pointers wrap at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= OWNER_CORE;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/obi_sba_arbiter.sv
// Round-robin arbiter merging the core data port (m0) and the debug SBA master (m1)
// onto the single mm_ram port, with in-order response routing and bounded outstanding.
module obi_sba_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    resp_err_o
);

    import obi_arb_pkg::*;

    owner_id_e winner_s;
    owner_id_e prio_r;
    owner_id_e lock_id_r;
    owner_id_e head_s;
    logic      lock_valid_r;
    logic      full_s;
    logic      empty_s;
    logic      hs_s;
    logic      resp_err_r;

    assign s_req_o = (m0_req_i | m1_req_i) & ~full_s;
    assign hs_s    = s_req_o & s_gnt_i;

    // Winner selection: a stalled request keeps its owner until the slave grants it.
    always_comb begin
        winner_s = OWNER_CORE;
        if (lock_valid_r) begin
            winner_s = lock_id_r;
        end else if (m0_req_i && !m1_req_i) begin
            winner_s = OWNER_CORE;
        end else if (m1_req_i && !m0_req_i) begin
            winner_s = OWNER_SBA;
        end else if (m0_req_i && m1_req_i) begin
            winner_s = prio_r;
        end else begin
            winner_s = OWNER_CORE;
        end
    end

    // Slave-side attribute mux; idle cycles show master 0's attributes.
    always_comb begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
        if (s_req_o && (winner_s == OWNER_SBA)) begin
            s_addr_o  = m1_addr_i;
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_wdata_o = m1_wdata_i;
        end else begin
            s_addr_o  = m0_addr_i;
            s_we_o    = m0_we_i;
            s_be_o    = m0_be_i;
            s_wdata_o = m0_wdata_i;
        end
    end

    assign m0_gnt_o = hs_s & (winner_s == OWNER_CORE);
    assign m1_gnt_o = hs_s & (winner_s == OWNER_SBA);

    // Round-robin priority, stall lock and sticky spurious-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_r       <= OWNER_CORE;
            lock_valid_r <= 1'b0;
            lock_id_r    <= OWNER_CORE;
            resp_err_r   <= 1'b0;
        end else begin
            if (hs_s) begin
                prio_r       <= owner_id_e'(~winner_s);
                lock_valid_r <= 1'b0;
            end else if (s_req_o) begin
                lock_valid_r <= 1'b1;
                lock_id_r    <= winner_s;
            end
            if (s_rvalid_i && empty_s) begin
                resp_err_r <= 1'b1;
            end
        end
    end

    obi_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (hs_s),
        .push_id (winner_s),
        .pop     (s_rvalid_i),
        .full    (full_s),
        .empty   (empty_s),
        .head    (head_s)
    );

    assign m0_rvalid_o = s_rvalid_i & ~empty_s & (head_s == OWNER_CORE);
    assign m1_rvalid_o = s_rvalid_i & ~empty_s & (head_s == OWNER_SBA);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign resp_err_o  = resp_err_r;

endmodule

// File: tb/tb_obi_sba_arbiter.sv
// Directed bench for obi_sba_arbiter: request-side checks inline, responses
// checked by a scoreboard monitor against expected (owner, rdata) pairs.
module tb_obi_sba_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i = 32'h0, m1_addr_i = 32'h0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_be_i = 4'hF, m1_be_i = 4'hF;
    logic [31:0] m0_wdata_i = 32'h0, m1_wdata_i = 32'h0;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i = 1'b0;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i = 32'h0;
    logic        resp_err_o;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk_i = ~clk_i;

    obi_sba_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m0_req_i    (m0_req_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_be_i     (m0_be_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_be_i     (m1_be_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt_i),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .resp_err_o  (resp_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic g,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk_i);
        #1;
        m0_req_i   = r0;
        m1_req_i   = r1;
        s_gnt_i    = g;
        s_rvalid_i = rv;
        s_rdata_i  = rd;
    endtask

    task automatic expect_rsp(input logic owner, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic check_req(input string name, input logic req, input logic g0,
                             input logic g1, input logic [31:0] addr);
        @(negedge clk_i);
        check({name, "_sreq"}, {31'd0, s_req_o}, {31'd0, req});
        check({name, "_gnt0"}, {31'd0, m0_gnt_o}, {31'd0, g0});
        check({name, "_gnt1"}, {31'd0, m1_gnt_o}, {31'd0, g1});
        if (req) check({name, "_addr"}, s_addr_o, addr);
    endtask

    // Response monitor: every master rvalid must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (m0_rvalid_o || m1_rvalid_o) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rsp_unexpected: got rvalid m0=%0b m1=%0b, expected none", m0_rvalid_o, m1_rvalid_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_both", {31'd0, m0_rvalid_o & m1_rvalid_o}, 32'd0);
                check("rsp_owner", {31'd0, m1_rvalid_o}, {31'd0, e.owner});
                check("rsp_data", e.owner ? m1_rdata_o : m0_rdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_sreq", {31'd0, s_req_o}, 32'd0);
        check("rst_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd0);
        check("rst_rvalid", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
        check("rst_err", {31'd0, resp_err_o}, 32'd0);

        // Core-only read
        m0_addr_i = 32'h100;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b0, 32'hDEADBEEF);
        check_req("core_only", 1'b1, 1'b1, 1'b0, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk_i);
        check("core_only_m1rv", {31'd0, m1_rvalid_o}, 32'd0);
        check("core_only_m0rv", {31'd0, m0_rvalid_o}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset so round-robin starts at the core
        #1 rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Round-robin: both request, responses streamed one cycle behind
        m0_addr_i = 32'h200;
        m1_addr_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, (i > 0), 32'hA0 + 32'(i) - 32'd1);
            expect_rsp(i[0], 32'hA0 + 32'(i));
            check_req($sformatf("rr%0d", i), 1'b1, ~i[0], i[0], i[0] ? 32'h300 : 32'h200);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Slave stall: core wins and stays locked for 3 cycles
        m0_addr_i = 32'h400;
        m1_addr_i = 32'h500;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check_req($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b0, 32'h400);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b0, 32'h33);
        check_req("stall_gnt", 1'b1, 1'b1, 1'b0, 32'h400);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h33);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Full: SBA then core granted, third request blocked until a response
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b1, 32'h44);
        check_req("full_g0", 1'b1, 1'b0, 1'b1, 32'h500);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b0, 32'h55);
        check_req("full_g1", 1'b1, 1'b1, 1'b0, 32'h400);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
        check_req("full_blk", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
        expect_rsp(1'b1, 32'h66);
        check_req("full_rel", 1'b1, 1'b0, 1'b1, 32'h500);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h66);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Interleaved owners: core then SBA, responses at +2 and +3
        m0_addr_i = 32'h600;
        m1_addr_i = 32'h700;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b0, 32'h11);
        check_req("il_core", 1'b1, 1'b1, 1'b0, 32'h600);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b1, 32'h22);
        check_req("il_sba", 1'b1, 1'b0, 1'b1, 32'h700);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("pre_spur_err", {31'd0, resp_err_o}, 32'd0);

        // Spurious response with empty FIFO
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD);
        @(negedge clk_i);
        check("spur_rvalid", {30'd0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("spur_err", {31'd0, resp_err_o}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("spur_err_sticky", {31'd0, resp_err_o}, 32'd1);

        // Reset pulse clears the flag and restores core priority
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst2_err", {31'd0, resp_err_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        m0_addr_i = 32'h800;
        m1_addr_i = 32'h900;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        expect_rsp(1'b0, 32'h77);
        check_req("rst2_prio", 1'b1, 1'b1, 1'b0, 32'h800);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
